random_walk_integrator: RTL and testbench

Consumes the signed 4-bit random acceleration produced by the LFSR source (`random_acc`, range −7..+7) and integrates it into a bounded velocity and a bounded position at a fixed update rate. It sits between the random source and the CPU's memory-mapped I/O. The CPU reads a coherent position/velocity snapshot through a four-phase request/acknowledge handshake.

---
 rtl/random_walk_integrator_if.sv | 23 ++
 rtl/random_walk_integrator.sv | 232 +++++++++++++++++++++++
 tb/tb_random_walk_integrator.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/random_walk_integrator_if.sv
// random_walk_integrator_if
//   CPU-side snapshot bus of the random walk integrator. It carries a
//   four-phase level handshake: the CPU holds rd_req high, and the
//   integrator answers with rd_ack plus a frozen position/velocity pair.
//
//   Signals:
//     rd_req    CPU snapshot request (level)
//     rd_ack    snapshot valid / acknowledge
//     snap_pos  unsigned 16-bit position snapshot
//     snap_vel  signed 8-bit velocity snapshot
//
//   Modports:
//     master    CPU side (drives rd_req)
//     slave     integrator side (drives rd_ack and the snapshot)
interface random_walk_integrator_if;
  logic        rd_req;
  logic        rd_ack;
  logic [15:0] snap_pos;
  logic [7:0]  snap_vel;

  modport master (output rd_req, input rd_ack, snap_pos, snap_vel);
  modport slave  (input rd_req, output rd_ack, snap_pos, snap_vel);
endinterface

// File: rtl/random_walk_integrator.sv
// random_walk_integrator
//   Integrates a signed 4-bit random acceleration into a bounded velocity
//   and a bounded position once every TICK_DIV clock cycles, and serves
//   coherent position/velocity snapshots to the CPU over a four-phase
//   request/acknowledge handshake.
//
//   Build option:
//     RWI_BOUNCE_EN  defined   -> position reflects off the limits and the
//                                 velocity changes sign
//                    undefined -> position wraps around the legal range and
//                                 the velocity is kept
//
//   Parameters:
//     TICK_DIV  cycles between updates (>= 5)
//     VMAX      velocity magnitude limit (<= 127, <= POS_MAX - POS_MIN)
//     POS_MIN   lowest legal position
//     POS_MAX   highest legal position (<= 32767)
//     POS_INIT  position after reset
//
//   Ports:
//     clock         rising-edge clock
//     reset         asynchronous, active-high reset
//     enable        run integration
//     random_acc    signed acceleration sample (-8 is treated as 0)
//     rd_bus        snapshot bus (slave side)
//     pos           live position register
//     vel           live signed velocity register
//     update_pulse  one-cycle strobe while freshly committed pos/vel show
module random_walk_integrator #(
  parameter int TICK_DIV = 1000,
  parameter int VMAX     = 63,
  parameter int POS_MIN  = 0,
  parameter int POS_MAX  = 639,
  parameter int POS_INIT = 320
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [3:0]                random_acc,
  random_walk_integrator_if.slave   rd_bus,
  output logic [15:0]               pos,
  output logic [7:0]                vel,
  output logic                      update_pulse
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0]      LAST_COUNT = CW'(TICK_DIV - 1);
  localparam logic signed [8:0]  VMAX9      = 9'(VMAX);
  localparam logic signed [7:0]  VMAX8      = 8'(VMAX);
  localparam logic signed [16:0] PMAX17     = 17'(POS_MAX);
  localparam logic signed [16:0] PMIN17     = 17'(POS_MIN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_VEL,
    ST_POS,
    ST_PUBLISH
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]      count;
  logic               tick;
  logic signed [3:0]  acc_q;
  logic signed [7:0]  vel_n;
  logic signed [8:0]  v9;
  logic signed [7:0]  vel_clamped;
  logic signed [16:0] p17;
  logic signed [16:0] pos_sel;
  logic signed [7:0]  vel_n2;
  logic               latch_acc;
  logic               load_vel;
  logic               commit;

  // Tick divider: counts only while enabled and restarts from zero on every
  // enable, so the first update lands a full period after enable rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == LAST_COUNT) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // The tick is registered so the sequencer sees a clean one-cycle strobe;
  // this adds the one cycle that puts the first tick TICK_DIV cycles after
  // enable rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick <= 1'b0;
    end else begin
      tick <= enable && (count == LAST_COUNT);
    end
  end

  // Sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Sequencer next state and datapath strobes. The results are committed on
  // the edge that enters PUBLISH, so pos/vel already hold the new values in
  // the cycle update_pulse is high. Once started the sequence always runs to
  // completion, independent of enable.
  always_comb begin
    next_state = state;
    latch_acc  = 1'b0;
    load_vel   = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          next_state = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        latch_acc  = 1'b1;
        next_state = ST_VEL;
      end
      ST_VEL: begin
        load_vel   = 1'b1;
        next_state = ST_POS;
      end
      ST_POS: begin
        commit     = 1'b1;
        next_state = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Velocity step: 9-bit signed sum cannot overflow, then clamp to +-VMAX.
  always_comb begin
    v9 = {vel[7], vel} + {{5{acc_q[3]}}, acc_q};
    if (v9 > VMAX9) begin
      vel_clamped = VMAX8;
    end else if (v9 < -VMAX9) begin
      vel_clamped = -VMAX8;
    end else begin
      vel_clamped = v9[7:0];
    end
  end

  // Position step and boundary handling. The 17-bit signed sum covers the
  // full unsigned position range plus one velocity step either way.
`ifdef RWI_BOUNCE_EN
  localparam logic signed [16:0] PMAX2 = 17'(2 * POS_MAX);
  localparam logic signed [16:0] PMIN2 = 17'(2 * POS_MIN);

  always_comb begin
    p17     = $signed({1'b0, pos}) + $signed({{9{vel_n[7]}}, vel_n});
    pos_sel = p17;
    vel_n2  = vel_n;
    if (p17 > PMAX17) begin
      pos_sel = PMAX2 - p17;
      vel_n2  = -vel_n;
    end else if (p17 < PMIN17) begin
      pos_sel = PMIN2 - p17;
      vel_n2  = -vel_n;
    end
  end
`else
  localparam logic signed [16:0] SPAN17 = 17'(POS_MAX - POS_MIN + 1);

  always_comb begin
    p17     = $signed({1'b0, pos}) + $signed({{9{vel_n[7]}}, vel_n});
    pos_sel = p17;
    vel_n2  = vel_n;
    if (p17 > PMAX17) begin
      pos_sel = p17 - SPAN17;
    end else if (p17 < PMIN17) begin
      pos_sel = p17 + SPAN17;
    end
  end
`endif

  // Datapath registers. -8 is outside the symmetric acceleration range, so
  // it is latched as zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q        <= '0;
      vel_n        <= '0;
      pos          <= 16'(POS_INIT);
      vel          <= '0;
      update_pulse <= 1'b0;
    end else begin
      if (latch_acc) begin
        acc_q <= (random_acc == 4'b1000) ? 4'sd0 : random_acc;
      end
      if (load_vel) begin
        vel_n <= vel_clamped;
      end
      if (commit) begin
        pos <= 16'(pos_sel);
        vel <= vel_n2;
      end
      update_pulse <= commit;
    end
  end

  // Snapshot handshake. A capture on the commit edge reads the old pos/vel,
  // giving the CPU a coherent pair. The snapshot stays frozen while rd_ack
  // is high, and a new request is taken only after rd_ack has dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_bus.rd_ack   <= 1'b0;
      rd_bus.snap_pos <= '0;
      rd_bus.snap_vel <= '0;
    end else if (rd_bus.rd_req && !rd_bus.rd_ack) begin
      rd_bus.rd_ack   <= 1'b1;
      rd_bus.snap_pos <= pos;
      rd_bus.snap_vel <= vel;
    end else if (!rd_bus.rd_req && rd_bus.rd_ack) begin
      rd_bus.rd_ack   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_random_walk_integrator.sv
// tb_random_walk_integrator
//   Directed bench for random_walk_integrator with TICK_DIV = 8. A reference
//   model predicts update timing, position/velocity arithmetic and the
//   snapshot handshake, and it is compared against the DUT on every falling
//   edge. Literal expectations worked out by hand pin the model at key points.
//   Compile with RWI_BOUNCE_EN defined to check the reflecting build.
module tb_random_walk_integrator;

  localparam int TD    = 8;
  localparam int VMAX  = 63;
  localparam int PMIN  = 0;
  localparam int PMAX  = 639;
  localparam int PINIT = 320;
  localparam int SPAN  = PMAX - PMIN + 1;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [3:0]  random_acc;
  logic [15:0] pos;
  logic [7:0]  vel;
  logic        update_pulse;

  random_walk_integrator_if bus ();

  random_walk_integrator #(
    .TICK_DIV (TD),
    .VMAX     (VMAX),
    .POS_MIN  (PMIN),
    .POS_MAX  (PMAX),
    .POS_INIT (PINIT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .random_acc   (random_acc),
    .rd_bus       (bus),
    .pos          (pos),
    .vel          (vel),
    .update_pulse (update_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int pulse_count = 0;

  // Reference model state: values expected after the most recent edge.
  bit model_ok = 0;
  int m_pos, m_vel;
  int exp_pulse, exp_ack, exp_snap_pos, exp_snap_vel;
  int run_len;
  int pend;
  int pend_acc;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_pos        = PINIT;
    m_vel        = 0;
    exp_pulse    = 0;
    exp_ack      = 0;
    exp_snap_pos = 0;
    exp_snap_vel = 0;
    run_len      = 0;
    pend         = 0;
    pend_acc     = 0;
    model_ok     = 1;
  endtask

  // One update from the rules: clamp velocity, move, then handle the edges.
  task automatic model_update();
    int v, p;
    v = m_vel + pend_acc;
    if (v > VMAX) v = VMAX;
    if (v < -VMAX) v = -VMAX;
    p = m_pos + v;
`ifdef RWI_BOUNCE_EN
    if (p > PMAX) begin
      p = 2 * PMAX - p;
      v = -v;
    end else if (p < PMIN) begin
      p = 2 * PMIN - p;
      v = -v;
    end
`else
    if (p > PMAX) p = p - SPAN;
    else if (p < PMIN) p = p + SPAN;
`endif
    m_pos = p;
    m_vel = v;
  endtask

  // Advance the model across the next rising edge using the inputs that
  // edge will sample. An update starts after every TD consecutive enabled
  // edges, samples the acceleration two edges later and commits two after.
  task automatic model_step();
    int a;
    if (bus.rd_req && exp_ack == 0) begin
      exp_ack      = 1;
      exp_snap_pos = m_pos;
      exp_snap_vel = m_vel;
    end else if (!bus.rd_req && exp_ack == 1) begin
      exp_ack = 0;
    end
    exp_pulse = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 2) begin
        a = int'($signed(random_acc));
        if (a == -8) a = 0;
        pend_acc = a;
      end
      if (pend == 0) begin
        model_update();
        exp_pulse = 1;
      end
    end
    if (enable) run_len++;
    else run_len = 0;
    if (enable && run_len % TD == 0) pend = 4;
  endtask

  // Compare process: check the DUT against the model on every falling edge,
  // then advance the model.
  always @(negedge clock) begin
    if (reset) model_reset();
    if (model_ok) begin
      check_output("pulse", int'(update_pulse), exp_pulse);
      check_output("pos", int'(pos), m_pos);
      check_output("vel", int'($signed(vel)), m_vel);
      check_output("rd_ack", int'(bus.rd_ack), exp_ack);
      check_output("snap_pos", int'(bus.snap_pos), exp_snap_pos);
      check_output("snap_vel", int'($signed(bus.snap_vel)), exp_snap_vel);
    end
    if (update_pulse) pulse_count++;
    if (!reset && model_ok) model_step();
  end

  task automatic apply_stimulus(input logic en, input logic [3:0] acc);
    @(posedge clock);
    #1;
    enable     = en;
    random_acc = acc;
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1;
    reset      = 1'b1;
    enable     = 1'b0;
    bus.rd_req = 1'b0;
    @(negedge clock);
    check_output("rst_pos", int'(pos), PINIT);
    check_output("rst_vel", int'(vel), 0);
    check_output("rst_pulse", int'(update_pulse), 0);
    check_output("rst_ack", int'(bus.rd_ack), 0);
    check_output("rst_snap_pos", int'(bus.snap_pos), 0);
    check_output("rst_snap_vel", int'(bus.snap_vel), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Wait (bounded) for the next update strobe; returns on that falling edge.
  task automatic wait_pulse(input string name);
    bit got;
    got = 0;
    for (int n = 0; n < 3 * TD && !got; n++) begin
      @(negedge clock);
      if (update_pulse) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL %s: got no update_pulse expected one within %0d cycles", name, 3 * TD);
    end
  endtask

  task automatic wait_updates(input int n, input string name);
    for (int i = 0; i < n; i++) wait_pulse(name);
  endtask

  initial begin
    int pc0;
    reset      = 1'b1;
    enable     = 1'b0;
    random_acc = 4'd0;
    bus.rd_req = 1'b0;
    apply_reset();

    // Reset and enable: first strobe 12 cycles after enable, then every 8.
    apply_stimulus(1'b1, 4'd3);
    repeat (11) @(posedge clock);
    @(negedge clock);
    check_output("a_no_early_pulse", int'(update_pulse), 0);
    @(negedge clock);
    check_output("a_pulse1", int'(update_pulse), 1);
    check_output("a_pos1", int'(pos), 323);
    check_output("a_vel1", int'($signed(vel)), 3);
    repeat (8) @(negedge clock);
    check_output("a_pulse2", int'(update_pulse), 1);
    check_output("a_pos2", int'(pos), 329);
    check_output("a_vel2", int'($signed(vel)), 6);
    repeat (8) @(negedge clock);
    check_output("a_pulse3", int'(update_pulse), 1);
    check_output("a_pos3", int'(pos), 338);
    check_output("a_vel3", int'($signed(vel)), 9);

    // Snapshot coherence: request sampled on the commit edge of update 4.
    repeat (7) @(posedge clock);
    #1;
    bus.rd_req = 1'b1;
    @(negedge clock);
    check_output("s_ack_before", int'(bus.rd_ack), 0);
    @(negedge clock);
    check_output("s_ack_rise", int'(bus.rd_ack), 1);
    check_output("s_pulse", int'(update_pulse), 1);
    check_output("s_snap_pos_old", int'(bus.snap_pos), 338);
    check_output("s_snap_vel_old", int'($signed(bus.snap_vel)), 9);
    check_output("s_pos_new", int'(pos), 350);
    repeat (18) @(negedge clock);
    check_output("s_snap_pos_frozen", int'(bus.snap_pos), 338);
    check_output("s_snap_vel_frozen", int'($signed(bus.snap_vel)), 9);
    check_output("s_pos_live", int'(pos), 383);
    check_output("s_vel_live", int'($signed(vel)), 18);
    @(posedge clock);
    #1;
    bus.rd_req = 1'b0;
    @(negedge clock);
    check_output("s_ack_hold", int'(bus.rd_ack), 1);
    @(negedge clock);
    check_output("s_ack_fall", int'(bus.rd_ack), 0);
    @(posedge clock);
    #1;
    bus.rd_req = 1'b1;
    repeat (2) @(negedge clock);
    check_output("s2_ack", int'(bus.rd_ack), 1);
    check_output("s2_snap_pos", int'(bus.snap_pos), 383);
    check_output("s2_snap_vel", int'($signed(bus.snap_vel)), 18);
    @(posedge clock);
    #1;
    bus.rd_req = 1'b0;

    // Velocity saturation with +7, then -8 treated as zero.
    apply_reset();
    apply_stimulus(1'b1, 4'd7);
    wait_updates(9, "b_wait");
    check_output("b_vel_sat", int'($signed(vel)), 63);
    check_output("b_pos9", int'(pos), 635);
    wait_pulse("b_wait10");
`ifdef RWI_BOUNCE_EN
    check_output("b_pos10", int'(pos), 580);
    check_output("b_vel10", int'($signed(vel)), -63);
`else
    check_output("b_pos10", int'(pos), 58);
    check_output("b_vel10", int'($signed(vel)), 63);
`endif
    apply_stimulus(1'b1, 4'b1000);
    wait_pulse("b_wait11");
`ifdef RWI_BOUNCE_EN
    check_output("b_pos11", int'(pos), 517);
    check_output("b_vel11", int'($signed(vel)), -63);
`else
    check_output("b_pos11", int'(pos), 121);
    check_output("b_vel11", int'($signed(vel)), 63);
`endif
    apply_stimulus(1'b1, 4'd7);
    wait_updates(1, "b_wait12");

    // Boundary: reach pos 630 with vel +20, then coast over the top edge.
    apply_reset();
    apply_stimulus(1'b1, 4'd5);
    wait_updates(4, "c_ramp");
    apply_stimulus(1'b1, 4'd0);
    wait_updates(13, "c_coast");
    check_output("c_pos_pre", int'(pos), 630);
    check_output("c_vel_pre", int'($signed(vel)), 20);
    wait_pulse("c_edge");
`ifdef RWI_BOUNCE_EN
    check_output("c_pos_edge", int'(pos), 628);
    check_output("c_vel_edge", int'($signed(vel)), -20);
`else
    check_output("c_pos_edge", int'(pos), 10);
    check_output("c_vel_edge", int'($signed(vel)), 20);
`endif

    // Abort: reset asserted while the sequencer is in VEL.
    apply_reset();
    apply_stimulus(1'b1, 4'd3);
    repeat (10) @(posedge clock);
    #1;
    reset  = 1'b1;
    enable = 1'b0;
    pc0    = pulse_count;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    check_output("e_no_pulse", pulse_count - pc0, 0);
    check_output("e_pos", int'(pos), 320);
    check_output("e_vel", int'(vel), 0);

    // Disable: enable dropped while the sequencer is in SAMPLE.
    apply_reset();
    apply_stimulus(1'b1, 4'd3);
    repeat (9) @(posedge clock);
    #1;
    enable = 1'b0;
    pc0    = pulse_count;
    repeat (40) @(posedge clock);
    #1;
    check_output("f_one_pulse", pulse_count - pc0, 1);
    check_output("f_pos", int'(pos), 323);
    check_output("f_vel", int'($signed(vel)), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
